// File: rtl/thor2021_pkg.sv
// rtl/thor2021_pkg.sv - SM4 constants, S-box, engine state enum and rotate helper
package thor2021_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_KEYED  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

    localparam logic [31:0] CK [32] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/thor2021_sm4_tfunc.sv
// rtl/thor2021_sm4_tfunc.sv - four parallel S-boxes followed by L (data) or L' (key schedule)
module thor2021_sm4_tfunc
    import thor2021_pkg::*;
(
    input  logic [31:0] din,
    input  logic        key_mode,
    output logic [31:0] dout
);

    logic [31:0] b;

    assign b = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};

    always_comb begin
        if (key_mode) begin
            dout = b ^ rotl32(b, 13) ^ rotl32(b, 23);
        end else begin
            dout = b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
        end
    end

endmodule

// File: rtl/thor2021_sm4_engine.sv
// rtl/thor2021_sm4_engine.sv - iterative SM4 engine, one round per clock, shared T datapath
// Define SM4_DECRYPT_EN to honour in_dir_i (reverse round-key order); otherwise every block is encrypted.
module thor2021_sm4_engine
    import thor2021_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         key_valid_i,
    input  logic [127:0] key_i,
    output logic         key_ready_o,
    input  logic         in_valid_i,
    input  logic         in_dir_i,
    input  logic [127:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [127:0] out_data_o,
    input  logic         out_ready_i,
    output logic         keyed_o
);

    state_e      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] w [4];
    logic [31:0] rk [32];
    logic [4:0]  rk_idx;
    logic [31:0] t_in, t_out, w_new;
    logic        key_xfer, blk_xfer, key_mode;

    assign key_xfer = key_valid_i && key_ready_o;
    assign blk_xfer = in_valid_i && in_ready_o;
    assign key_mode = (state == ST_KEYEXP);

`ifdef SM4_DECRYPT_EN
    logic dir_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q <= 1'b0;
        end else if (blk_xfer) begin
            dir_q <= in_dir_i;
        end
    end

    // 31 - cnt for a 5-bit counter is its bitwise complement
    assign rk_idx = dir_q ? ~cnt : cnt;
`else
    logic unused_dir;
    assign unused_dir = in_dir_i;
    assign rk_idx     = cnt;
`endif

    // The four words hold K during key expansion and X during a block run
    assign t_in  = w[1] ^ w[2] ^ w[3] ^ (key_mode ? CK[cnt] : rk[rk_idx]);
    assign w_new = w[0] ^ t_out;

    thor2021_sm4_tfunc u_tfunc (
        .din      (t_in),
        .key_mode (key_mode),
        .dout     (t_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (key_xfer) state_nxt = ST_KEYEXP;
            ST_KEYEXP: if (cnt == 5'd31) state_nxt = ST_KEYED;
            ST_KEYED: begin
                if (key_xfer) begin
                    state_nxt = ST_KEYEXP;
                end else if (blk_xfer) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:    if (cnt == 5'd31) state_nxt = ST_DONE;
            ST_DONE:   if (out_ready_i) state_nxt = ST_KEYED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        key_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        keyed_o     = 1'b0;
        case (state)
            ST_IDLE:  key_ready_o = 1'b1;
            ST_KEYED: begin
                key_ready_o = 1'b1;
                in_ready_o  = !key_valid_i;
                keyed_o     = 1'b1;
            end
            ST_RUN:   keyed_o = 1'b1;
            ST_DONE: begin
                out_valid_o = 1'b1;
                keyed_o     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            for (int i = 0; i < 4; i++) w[i] <= '0;
        end else if (key_xfer) begin
            cnt  <= '0;
            w[0] <= key_i[127:96] ^ FK[0];
            w[1] <= key_i[95:64]  ^ FK[1];
            w[2] <= key_i[63:32]  ^ FK[2];
            w[3] <= key_i[31:0]   ^ FK[3];
        end else if (blk_xfer) begin
            cnt  <= '0;
            w[0] <= in_data_i[127:96];
            w[1] <= in_data_i[95:64];
            w[2] <= in_data_i[63:32];
            w[3] <= in_data_i[31:0];
        end else if (state == ST_KEYEXP || state == ST_RUN) begin
            cnt  <= cnt + 5'd1;
            w[0] <= w[1];
            w[1] <= w[2];
            w[2] <= w[3];
            w[3] <= w_new;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) rk[i] <= '0;
        end else if (state == ST_KEYEXP) begin
            rk[cnt] <= w_new;
        end
    end

    assign out_data_o = {w[3], w[2], w[1], w[0]};

endmodule

// File: tb/tb_thor2021_sm4_engine.sv
// tb/tb_thor2021_sm4_engine.sv - randomized self-checking bench with a timestamp-based SM4 reference model
module tb_thor2021_sm4_engine;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         key_valid_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         key_ready_o;
    logic         in_valid_i = 1'b0;
    logic         in_dir_i = 1'b0;
    logic [127:0] in_data_i = '0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [127:0] out_data_o;
    logic         out_ready_i = 1'b0;
    logic         keyed_o;

    localparam logic [127:0] KAT_K = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_C = 128'h681edf34d206965e86b3e94f536e4246;

    int checks = 0;
    int errors = 0;

    thor2021_sm4_engine dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_valid_i (key_valid_i),
        .key_i       (key_i),
        .key_ready_o (key_ready_o),
        .in_valid_i  (in_valid_i),
        .in_dir_i    (in_dir_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .keyed_o     (keyed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input logic [127:0] act, input logic [127:0] exp, input string nm);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] sub(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = thor2021_pkg::SBOX[x[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sm4_ref(input logic [127:0] key, input logic [127:0] blk, input bit dec);
        logic [31:0] k [36];
        logic [31:0] x [36];
        logic [31:0] rk [32];
        logic [31:0] fk [4];
        logic [31:0] ck, b;
        fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
        for (int i = 0; i < 4; i++) begin
            k[i] = key[127-32*i -: 32] ^ fk[i];
            x[i] = blk[127-32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
            b = sub(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ b ^ rl(b, 13) ^ rl(b, 23);
            rk[i] = k[i+4];
        end
        for (int i = 0; i < 32; i++) begin
            b = sub(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[dec ? 31 - i : i]);
            x[i+4] = x[i] ^ b ^ rl(b, 2) ^ rl(b, 10) ^ rl(b, 18) ^ rl(b, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // Model state is a pair of timestamps: the edge a key / block was accepted (-1 = none)
    int n = 0;
    int key_acc = -1;
    int blk_acc = -1;
    int key_took = 0, blk_took = 0, out_took = 0;
    logic [127:0] cur_key = '0;
    logic [127:0] exp_data = '0;
    logic [127:0] last_out = '0;

    always @(negedge clk_i) begin
        bit keyexp, keyed, run, done, e_kr, e_ir, dir;
        n++;
        if (!rst_ni) begin
            key_acc = -1;
            blk_acc = -1;
        end
        keyexp = key_acc >= 0 && n < key_acc + 32;
        keyed  = key_acc >= 0 && !keyexp;
        run    = blk_acc >= 0 && n < blk_acc + 32;
        done   = blk_acc >= 0 && !run;
        e_kr   = !keyexp && !run && !done;
        e_ir   = keyed && !run && !done && !key_valid_i;
        chk(key_ready_o, e_kr, "key_ready");
        chk(in_ready_o, e_ir, "in_ready");
        chk(out_valid_o, done, "out_valid");
        chk(keyed_o, keyed, "keyed");
        if (!rst_ni) chk(out_data_o, '0, "reset_out_data");
        if (done) chk(out_data_o, exp_data, "out_data");
        if (rst_ni) begin
`ifdef SM4_DECRYPT_EN
            dir = in_dir_i;
`else
            dir = 1'b0;
`endif
            if (key_valid_i && e_kr) begin
                key_acc = n + 1;
                cur_key = key_i;
                key_took++;
            end
            if (in_valid_i && e_ir) begin
                blk_acc  = n + 1;
                exp_data = sm4_ref(cur_key, in_data_i, dir);
                blk_took++;
            end
            if (done && out_ready_i) begin
                blk_acc  = -1;
                last_out = out_data_o;
                out_took++;
            end
        end
    end

    int rdy_mode = 0;
    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0:       out_ready_i = ($urandom_range(0, 2) == 0);
            1:       out_ready_i = 1'b0;
            default: out_ready_i = 1'b1;
        endcase
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_count(input int which, input int t0, input int limit, input string nm);
        int c;
        for (int i = 0; i < limit; i++) begin
            step();
            c = (which == 0) ? key_took : (which == 1) ? blk_took : out_took;
            if (c != t0) return;
        end
        chk(1'b0, 1'b1, nm);
    endtask

    task automatic send_key(input logic [127:0] k);
        int t0 = key_took;
        key_i = k;
        key_valid_i = 1'b1;
        wait_count(0, t0, 200, "key_accept_timeout");
        key_valid_i = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] d, input bit dir);
        int t0 = blk_took;
        in_data_i = d;
        in_dir_i = dir;
        in_valid_i = 1'b1;
        wait_count(1, t0, 200, "blk_accept_timeout");
        in_valid_i = 1'b0;
    endtask

    task automatic wait_out();
        wait_count(2, out_took, 300, "out_timeout");
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int t0;
        repeat (3) step();
        rst_ni = 1'b1;
        step();

        chk(sm4_ref(KAT_K, KAT_K, 1'b0), KAT_C, "model_kat_enc");
        chk(sm4_ref(KAT_K, KAT_C, 1'b1), KAT_K, "model_kat_dec");

        send_key(KAT_K);
        send_blk(KAT_K, 1'b0);
        wait_out();
        chk(last_out, KAT_C, "kat_enc");
`ifdef SM4_DECRYPT_EN
        send_blk(KAT_C, 1'b1);
        wait_out();
        chk(last_out, KAT_K, "kat_dec");
`else
        send_blk(KAT_K, 1'b1);
        wait_out();
        chk(last_out, KAT_C, "dir_ignored");
`endif

        // Backpressure: hold the result for 10+ cycles in DONE
        rdy_mode = 1;
        send_blk(rnd128(), 1'b0);
        repeat (42) step();
        rdy_mode = 2;
        wait_out();
        rdy_mode = 0;

        for (int it = 0; it < 5; it++) begin
            if ($urandom_range(0, 1) == 1) send_key(rnd128());
            for (int b = 0; b < 2; b++) begin
                send_blk(rnd128(), 1'($urandom_range(0, 1)));
                wait_out();
                repeat ($urandom_range(0, 3)) step();
            end
        end

        // Key and block offered together while keyed: key wins, block waits for the new schedule
        key_i = rnd128();
        in_data_i = rnd128();
        in_dir_i = 1'($urandom_range(0, 1));
        t0 = blk_took;
        key_valid_i = 1'b1;
        in_valid_i = 1'b1;
        wait_count(0, key_took, 10, "collision_key_timeout");
        key_valid_i = 1'b0;
        wait_count(1, t0, 200, "collision_blk_timeout");
        in_valid_i = 1'b0;
        wait_out();

        // Reset during round 15 of a run
        send_blk(rnd128(), 1'b0);
        repeat (15) step();
        rst_ni = 1'b0;
        repeat (2) step();
        rst_ni = 1'b1;
        in_data_i = rnd128();
        in_valid_i = 1'b1;
        t0 = blk_took;
        repeat (5) step();
        send_key(rnd128());
        wait_count(1, t0, 200, "post_reset_blk_timeout");
        in_valid_i = 1'b0;
        wait_out();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thor2021_sm4_engine.md
THOR2021_SM4_ENGINE -- requirements
Module: Thor2021_sm4_engine

Interface
REQ-001 The module SHALL have these ports, one per line: name, direction, width, meaning.
  clk_i  in  1  sole clock; all state updates on its rising edge
  rst_ni  in  1  asynchronous active-low reset
  key_valid_i  in  1  128-bit key offered
  key_i  in  128  SM4 master key, MK0 in [127:96]
  key_ready_o  out  1  engine can accept a key
  in_valid_i  in  1  block offered
  in_dir_i  in  1  0 = encrypt, 1 = decrypt
  in_data_i  in  128  input block, X0 in [127:96]
  in_ready_o  out  1  engine can accept a block
  out_valid_o  out  1  result available
  out_data_o  out  128  result block, Y0 in [127:96]
  out_ready_i  in  1  consumer accepts the result
  keyed_o  out  1  a complete round-key schedule is held

Function
REQ-002 A transfer SHALL occur on a rising edge where valid and ready are both high; valid and data SHALL be held by the source until that transfer.
REQ-003 The state machine SHALL have the states IDLE, KEYEXP, KEYED, RUN and DONE.
REQ-004 IDLE: key_ready_o=1, in_ready_o=0. A key transfer SHALL load K0..K3 = MK ^ FK and go to KEYEXP.
REQ-005 KEYEXP SHALL produce exactly one round key per cycle, rk[i] = K(i+4) = Ki ^ T'(Ki+1 ^ Ki+2 ^ Ki+3 ^ CK[i]), for i = 0..31, then go to KEYED; keyed_o SHALL rise on the same edge.
REQ-006 KEYED: key_ready_o=1 and in_ready_o=1. A key transfer SHALL restart KEYEXP and clear keyed_o. A block transfer SHALL load X0..X3 and go to RUN. If both transfer on the same edge, the key SHALL win and the block SHALL NOT be accepted, because in_ready_o is deasserted combinationally while key_valid_i is high.
REQ-007 RUN SHALL perform one round per cycle for exactly 32 cycles: X(i+4) = Xi ^ T(Xi+1 ^ Xi+2 ^ Xi+3 ^ rk[j]). For encrypt, j = i. For decrypt, j = 31-i.
REQ-008 After the 32nd round edge the engine SHALL enter DONE with out_data_o = {X35,X34,X33,X32} and out_valid_o=1, so the result is valid exactly 32 clocks after the accepting edge.
REQ-009 Latency SHALL NOT depend on key, data or direction, and no data-dependent early exit is permitted.
REQ-010 DONE SHALL hold out_data_o stable while out_ready_i=0. An out transfer SHALL return to KEYED and clear out_valid_o.
REQ-011 key_ready_o and in_ready_o SHALL be 0 in KEYEXP, RUN and DONE.
REQ-012 The round counter SHALL be 5 bits, SHALL wrap 31->0 exactly on state exit, and SHALL index the 32x32 round-key register file.
REQ-013 T SHALL be the S-box followed by L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24. T' SHALL be the S-box followed by L'(B) = B ^ B<<<13 ^ B<<<23.

Reset
REQ-014 When rst_ni is low, the engine SHALL immediately enter IDLE with key_ready_o=1, in_ready_o=0, out_valid_o=0, out_data_o=0 and keyed_o=0.
REQ-015 Reset SHALL zero every round-key, state-word and counter register. A reset asserted mid-KEYEXP or mid-RUN SHALL discard the operation without producing output.

Configuration
REQ-016 With SM4_DECRYPT_EN defined, in_dir_i SHALL select the key order as in REQ-007.
REQ-017 Without SM4_DECRYPT_EN, in_dir_i SHALL be ignored, every block SHALL be encrypted, and the reverse-index logic SHALL be absent.

Structure
REQ-018 Thor2021_pkg SHALL hold the FK[0:3] and CK[0:31] constants, the SM4 S-box table, and the engine state enum.
REQ-019 One sub-module, Thor2021_sm4_tfunc, SHALL implement four parallel S-boxes plus L or L' as selected by an input, and SHALL be shared between KEYEXP and RUN.

Verification
REQ-020 Known-answer encrypt: key and block 0123456789abcdeffedcba9876543210 -> out_data_o = 681edf34d206965e86b3e94f536e4246, out_valid_o high exactly 32 clocks after block accept.
REQ-021 Known-answer decrypt (SM4_DECRYPT_EN defined): same key, block 681edf34d206965e86b3e94f536e4246 with in_dir_i=1 -> 0123456789abcdeffedcba9876543210.
REQ-022 Backpressure: hold out_ready_i=0 for 10 cycles in DONE -> out_data_o stable and in_ready_o=0 throughout, then one transfer returns to KEYED.
REQ-023 Reset mid-RUN at round 15 -> all outputs at reset values, keyed_o=0, and a block offered next cycle is not accepted until a new key completes.
REQ-024 key_valid_i and in_valid_i high together in KEYED -> key accepted, block not accepted, keyed_o low for 32 cycles.
REQ-025 Constant time: two different keys and blocks in each direction -> identical accept-to-valid latency of 32 clocks.
